// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Buffered 8N1 UART receiver. The serial line is synchronised, oversampled
//   16x, start/stop bits are validated and each good byte is pushed into a
//   first-word-fall-through FIFO read with a level valid/rd_en handshake.
//   Framing and overrun errors are reported as sticky flags.
//
// Parameters
//   DIVISOR : clk cycles per oversample tick (baud = clk / (16*DIVISOR)), >= 2
//   DEPTH   : FIFO entries, power of two, 2..64
//
// Ports
//   clk       in  : system clock, rising edge
//   rst_n     in  : synchronous active-low reset
//   rx_in     in  : asynchronous serial line, idle high
//   rd_en     in  : pop request, honoured only while valid=1
//   dout      out : FIFO head byte, meaningful while valid=1
//   valid     out : FIFO non-empty
//   count     out : FIFO occupancy 0..DEPTH
//   frame_err out : sticky, a stop bit was sampled low
//   overrun   out : sticky, a good byte arrived while the FIFO was full
//   clr_err   in  : clears both sticky flags (a same-cycle set wins)
module uart_rx_fifo #(
  parameter int DIVISOR = 54,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_in,
  input  logic                   rd_en,
  output logic [7:0]             dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   frame_err,
  output logic                   overrun,
  input  logic                   clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] DIV_MAX  = CW'(DIVISOR - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_nxt;
  logic          rx_sync_p0, rx_sync_p1;
  logic          rxs;
  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          start_det, shift_en, push, frame_set, phase_wrap;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push_ok, ovr_set;

  // Stage p0/p1: two-flop synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_in;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rxs  = rx_sync_p1;
  assign tick = (div_cnt == DIV_MAX);

  // The start bit is sampled after 8 ticks (mid-bit); every later bit after 16.
  assign phase_wrap = (state == S_START) ? (phase == 4'd7) : (phase == 4'd15);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    shift_en  = 1'b0;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          start_det = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (tick && phase_wrap) state_nxt = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick && phase_wrap) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving mid-stop-bit lets a back-to-back start edge be caught.
        if (tick && phase_wrap) begin
          if (rxs) begin
            push      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tick divider and bit-timing counters; the divider restarts on the start edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= '0;
      bit_cnt <= '0;
    end else begin
      if (start_det || tick) div_cnt <= '0;
      else                   div_cnt <= div_cnt + 1'b1;

      if (start_det)
        phase <= '0;
      else if (tick && (state == S_START || state == S_DATA || state == S_STOP))
        phase <= phase_wrap ? 4'd0 : phase + 4'd1;

      if (start_det)     bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // LSB arrives first, so shift right and insert at the top
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {rxs, shreg[7:1]};
  end

  assign full    = (count == FULL_CNT);
  assign valid   = (count != '0);
  assign pop     = rd_en && valid;
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovr_set)      overrun   <= 1'b1;
      else if (clr_err) overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo (DIVISOR=4, DEPTH=8): directed table of frames,
// hand-written corner sequences and a randomized run against a queue model.
module tb_uart_rx_fifo;

  localparam int D     = 4;
  localparam int DEPTH = 8;
  localparam int BIT   = 16 * D;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx_in   = 1'b1;
  logic       rd_en   = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] dout;
  logic       valid;
  logic [3:0] count;
  logic       frame_err;
  logic       overrun;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_fifo #(.DIVISOR(D), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .rd_en    (rd_en),
    .dout     (dout),
    .valid    (valid),
    .count    (count),
    .frame_err(frame_err),
    .overrun  (overrun),
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr;
    int         n_pop;
    int         exp_cnt;
    logic [7:0] exp_head;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // All line-driving tasks start and end on a falling edge.
  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stop bit is sampled on the rising edge 2 sync + 1 detect + 152 ticks
  // after the first edge that sees the start bit; assert rd_en/clr_err there.
  task automatic frame_with_pulse(input logic [7:0] b, input logic stop,
                                  input logic do_rd, input logic do_clr);
    fork
      send_frame(b, stop);
      begin
        repeat (2 + 152 * D) @(posedge clk);
        @(negedge clk);
        rd_en   = do_rd;
        clr_err = do_clr;
        @(negedge clk);
        rd_en   = 1'b0;
        clr_err = 1'b0;
      end
    join
  endtask

  int         lat;
  int         seen;
  logic [7:0] q [$];
  logic       m_fe, m_ov;
  logic [7:0] rb;
  logic       rstop;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1, 1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 0, 1, 8'h3C, 1'b0, 1'b0};
    tbl[2] = '{8'h55, 1'b0, 1'b0, 0, 1, 8'h3C, 1'b1, 1'b0};
    tbl[3] = '{8'h81, 1'b1, 1'b1, 2, 2, 8'h3C, 1'b1, 1'b0};
    tbl[4] = '{8'h00, 1'b1, 1'b0, 1, 1, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 1'b1, 1'b0, 1, 1, 8'hFF, 1'b0, 1'b0};

    @(negedge clk);

    // Reset with the line toggling, then a long idle with no spurious push
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_in = i[0];
      @(negedge clk);
    end
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rx_in = 1'b1;
    rst_n = 1'b1;
    seen  = 0;
    repeat (200 * D) begin
      @(negedge clk);
      if (valid) seen++;
    end
    check("rst_idle_push", seen, 0);

    // Single byte with latency measurement
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (lat < 152 * D + 20) begin
          @(posedge clk);
          lat++;
          #1;
          if (valid) break;
        end
      end
    join
    check_range("latency", lat, 152 * D + 2, 152 * D + 4);
    check("single_dout", dout, 8'hA5);
    check("single_count", count, 1);
    pop_one();
    check("single_pop_valid", valid, 0);
    check("single_pop_count", count, 0);

    // Short glitch rejected, following byte received
    rx_in = 1'b0;
    idle(5 * D);
    rx_in = 1'b1;
    idle(20 * D);
    check("glitch_count", count, 0);
    check("glitch_frame_err", frame_err, 0);
    check("glitch_overrun", overrun, 0);
    send_frame(8'h3C, 1'b1);
    idle(4 * D);
    check("glitch_next_count", count, 1);
    check("glitch_next_dout", dout, 8'h3C);
    pop_one();

    // Table of frames from an empty FIFO
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop);
      rx_in = 1'b1;
      idle(4 * D);
      check($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
      if (tbl[i].exp_cnt > 0) check($sformatf("tbl%0d_head", i), dout, tbl[i].exp_head);
      check($sformatf("tbl%0d_frame_err", i), frame_err, tbl[i].exp_fe);
      check($sformatf("tbl%0d_overrun", i), overrun, tbl[i].exp_ov);
      if (tbl[i].clr) pulse_clr();
      for (int k = 0; k < tbl[i].n_pop; k++) pop_one();
    end
    check("tbl_end_count", count, 0);

    // Framing error followed by a held-low line: one event only
    do_reset();
    send_frame(8'h55, 1'b0);
    check("frm_frame_err", frame_err, 1);
    check("frm_count", count, 0);
    idle(20 * D);
    pulse_clr();
    idle(20 * D);
    check("frm_single_event", frame_err, 0);
    check("frm_break_count", count, 0);
    rx_in = 1'b1;
    idle(4 * D);
    send_frame(8'h81, 1'b1);
    idle(4 * D);
    check("frm_next_count", count, 1);
    check("frm_next_dout", dout, 8'h81);

    // Overrun across pointer wrap (pointers start at 1 after this pop)
    pop_one();
    check("ovr_pre_count", count, 0);
    for (int v = 1; v <= 9; v++) send_frame(8'(v), 1'b1);
    idle(4 * D);
    check("ovr_count", count, 8);
    check("ovr_overrun", overrun, 1);
    check("ovr_frame_err", frame_err, 0);
    for (int v = 1; v <= 8; v++) begin
      check($sformatf("ovr_read%0d", v), dout, v);
      pop_one();
    end
    check("ovr_drained", valid, 0);

    // Full FIFO with a pop on the push edge
    pulse_clr();
    check("full_clr_overrun", overrun, 0);
    for (int v = 16; v < 24; v++) send_frame(8'(v), 1'b1);
    idle(4 * D);
    check("full_count", count, 8);
    frame_with_pulse(8'h18, 1'b1, 1'b1, 1'b0);
    idle(4 * D);
    check("full_pop_overrun", overrun, 0);
    check("full_pop_count", count, 8);
    for (int v = 17; v <= 24; v++) begin
      check($sformatf("full_read%0h", v), dout, v);
      pop_one();
    end
    check("full_drained", valid, 0);

    // Push while empty with rd_en high: pop ignored
    frame_with_pulse(8'h42, 1'b1, 1'b1, 1'b0);
    idle(4 * D);
    check("empty_push_count", count, 1);
    check("empty_push_dout", dout, 8'h42);
    pop_one();

    // clr_err on the same edge as a framing error: set wins
    frame_with_pulse(8'h99, 1'b0, 1'b0, 1'b1);
    rx_in = 1'b1;
    idle(4 * D);
    check("setwins_frame_err", frame_err, 1);
    check("setwins_count", count, 0);
    pulse_clr();
    check("clr_frame_err", frame_err, 0);

    // Reset in the middle of data bits: partial byte never appears
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    rx_in = 1'b1;
    idle(3);
    rst_n = 1'b1;
    seen  = 0;
    repeat (200 * D) begin
      @(negedge clk);
      if (valid) seen++;
    end
    check("midrst_no_push", seen, 0);
    check("midrst_frame_err", frame_err, 0);
    send_frame(8'h5A, 1'b1);
    idle(4 * D);
    check("midrst_next_count", count, 1);
    check("midrst_next_dout", dout, 8'h5A);
    pop_one();

    // Randomized frames, errors, pops and clears against a queue model
    do_reset();
    q.delete();
    m_fe = 1'b0;
    m_ov = 1'b0;
    for (int it = 0; it < 30; it++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      send_frame(rb, rstop);
      rx_in = 1'b1;
      idle($urandom_range(4, 40));
      if (!rstop)                 m_fe = 1'b1;
      else if (q.size() == DEPTH) m_ov = 1'b1;
      else                        q.push_back(rb);
      check($sformatf("rnd%0d_count", it), count, q.size());
      check($sformatf("rnd%0d_frame_err", it), frame_err, m_fe);
      check($sformatf("rnd%0d_overrun", it), overrun, m_ov);
      for (int k = 0; k < ((it < 10) ? 0 : int'($urandom_range(0, 2))); k++) begin
        if (q.size() > 0) begin
          check($sformatf("rnd%0d_pop%0d", it, k), dout, q[0]);
          void'(q.pop_front());
        end
        pop_one();
      end
      if ($urandom_range(0, 4) == 0) begin
        pulse_clr();
        m_fe = 1'b0;
        m_ov = 1'b0;
      end
      check($sformatf("rnd%0d_post_count", it), count, q.size());
      check($sformatf("rnd%0d_post_valid", it), valid, (q.size() > 0) ? 1 : 0);
      check($sformatf("rnd%0d_post_overrun", it), overrun, m_ov);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
